// File: rtl/epc_reply_buffer.sv
// Reply buffer: frames the decoded RX bit stream, packs bytes MSB-first and commits CRC-good replies to a byte FIFO.
// Optional EPC_TIMESTAMP_EN adds a 16-bit cycle timestamp to the header (3-byte header instead of 1).
module epc_reply_buffer #(
  parameter int DEPTH        = 64,
  parameter int MAX_BITS     = 128,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       in_dat,
  input  logic       in_vld,
  input  logic       crc_ok,
  output logic [7:0] out_dat,
  output logic       out_vld,
  input  logic       out_rdy,
  output logic       out_last,
  output logic       frame_good,
  output logic       frame_bad,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
`ifdef EPC_TIMESTAMP_EN
  localparam int HDR = 3;
`else
  localparam int HDR = 1;
`endif
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] HDR_P   = PW'(HDR);
  localparam logic [7:0]    MAX_P   = 8'(MAX_BITS);
  localparam logic [TW-1:0] TMO_P   = TW'(IDLE_TIMEOUT);
  localparam logic [1:0]    HLAST_P = 2'(HDR - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, CHECK} state_t;

  logic [7:0] mem [DEPTH];

  state_t        state_q, state_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_com_q, wr_com_d;
  logic [PW-1:0] wr_spec_q, wr_spec_d;
  logic [7:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ovf_q, ovf_d;
  logic          pend_q, pend_d;
  logic          good_q, good_d;
  logic          bad_q, bad_d;
  logic          ovfp_q, ovfp_d;
  logic          in_data_q, in_data_d;
  logic [1:0]    hdr_pos_q, hdr_pos_d;
  logic [5:0]    rem_q, rem_d;

  logic          start;
  logic          wa_en;
  logic [AW-1:0] wa_addr;
  logic [7:0]    wa_data;
  logic          hdr_we;
  logic [PW-1:0] used;
  logic          byte_fits;
  logic          hdr_fits;
  logic [7:0]    shreg_shift;
  logic [7:0]    bit_cnt_inc;
  logic [7:0]    pad_byte;
  logic          pad_need;
  logic          ovf_eff;
  logic [PW-1:0] wr_end;
  logic          xfer;
  logic [8:0]    hdr_rem;
  logic [5:0]    rem_sel;

`ifdef EPC_TIMESTAMP_EN
  logic [15:0]   ts_cnt_q;
  logic [15:0]   ts_q;
  logic [AW-1:0] hdr_a1;
  logic [AW-1:0] hdr_a2;
  assign hdr_a1 = wr_com_q[AW-1:0] + AW'(1);
  assign hdr_a2 = wr_com_q[AW-1:0] + AW'(2);
`endif

  assign used        = wr_spec_q - rd_q;
  assign byte_fits   = used < DEPTH_P;
  assign hdr_fits    = (wr_com_q + HDR_P - rd_q) <= DEPTH_P;
  assign shreg_shift = {shreg_q[6:0], in_dat};
  assign bit_cnt_inc = bit_cnt_q + 8'd1;
  assign pad_need    = bit_cnt_q[2:0] != 3'd0;
  // Left-justify the partial byte so the first received bit lands in bit 7.
  assign pad_byte    = shreg_q << (4'd8 - {1'b0, bit_cnt_q[2:0]});
  assign ovf_eff     = ovf_q | (pad_need & ~byte_fits);

  always_comb begin
    state_d   = state_q;
    wr_com_d  = wr_com_q;
    wr_spec_d = wr_spec_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    tmo_d     = tmo_q;
    ovf_d     = ovf_q;
    pend_d    = pend_q;
    good_d    = 1'b0;
    bad_d     = 1'b0;
    ovfp_d    = 1'b0;
    start     = 1'b0;
    wa_en     = 1'b0;
    wa_addr   = wr_spec_q[AW-1:0];
    wa_data   = shreg_shift;
    hdr_we    = 1'b0;
    wr_end    = wr_spec_q;
    case (state_q)
      IDLE: begin
        pend_d = 1'b0;
        start  = frame_start | pend_q;
      end
      COLLECT: begin
        pend_d = 1'b0;
        if (frame_start) begin
          bad_d = 1'b1;
          start = 1'b1;
        end else if (bit_cnt_q == MAX_P || tmo_q == TMO_P) begin
          if (bit_cnt_q == 8'd0) begin
            state_d   = IDLE;
            wr_spec_d = wr_com_q;
          end else begin
            state_d = CHECK;
          end
        end else if (in_vld) begin
          shreg_d   = shreg_shift;
          bit_cnt_d = bit_cnt_inc;
          tmo_d     = '0;
          if (bit_cnt_inc[2:0] == 3'd0) begin
            if (byte_fits) begin
              wa_en     = 1'b1;
              wr_spec_d = wr_spec_q + PW'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      CHECK: begin
        pend_d  = frame_start;
        state_d = IDLE;
        if (pad_need && byte_fits) begin
          wa_en   = 1'b1;
          wa_data = pad_byte;
          wr_end  = wr_spec_q + PW'(1);
        end
        if (crc_ok && !ovf_eff) begin
          hdr_we    = 1'b1;
          wr_com_d  = wr_end;
          wr_spec_d = wr_end;
          good_d    = 1'b1;
        end else begin
          wr_spec_d = wr_com_q;
          bad_d     = 1'b1;
          ovfp_d    = ovf_eff;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort and fresh start share one path; wr_com_q is the rollback base either way.
    if (start) begin
      state_d   = COLLECT;
      wr_spec_d = wr_com_q + HDR_P;
      bit_cnt_d = '0;
      shreg_d   = '0;
      tmo_d     = '0;
      ovf_d     = ~hdr_fits;
    end
  end

  assign out_vld  = rd_q != wr_com_q;
  assign out_dat  = out_vld ? mem[rd_q[AW-1:0]] : 8'h00;
  assign out_last = out_vld & in_data_q & (rem_q == 6'd1);
  assign xfer     = out_vld & out_rdy;
  assign hdr_rem  = ({1'b0, out_dat} + 9'd7) >> 3;
  assign rem_sel  = (hdr_pos_q == 2'd0) ? hdr_rem[5:0] : rem_q;

  always_comb begin
    rd_d      = rd_q;
    in_data_d = in_data_q;
    hdr_pos_d = hdr_pos_q;
    rem_d     = rem_q;
    if (xfer) begin
      rd_d = rd_q + PW'(1);
      if (in_data_q) begin
        rem_d = rem_q - 6'd1;
        if (rem_q == 6'd1) in_data_d = 1'b0;
      end else begin
        rem_d = rem_sel;
        if (hdr_pos_q == HLAST_P) begin
          hdr_pos_d = 2'd0;
          in_data_d = rem_sel != 6'd0;
        end else begin
          hdr_pos_d = hdr_pos_q + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_q      <= '0;
      wr_com_q  <= '0;
      wr_spec_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      tmo_q     <= '0;
      ovf_q     <= 1'b0;
      pend_q    <= 1'b0;
      good_q    <= 1'b0;
      bad_q     <= 1'b0;
      ovfp_q    <= 1'b0;
      in_data_q <= 1'b0;
      hdr_pos_q <= '0;
      rem_q     <= '0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      wr_com_q  <= wr_com_d;
      wr_spec_q <= wr_spec_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      tmo_q     <= tmo_d;
      ovf_q     <= ovf_d;
      pend_q    <= pend_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      ovfp_q    <= ovfp_d;
      in_data_q <= in_data_d;
      hdr_pos_q <= hdr_pos_d;
      rem_q     <= rem_d;
    end
  end

`ifdef EPC_TIMESTAMP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 16'd1;
      if (start) ts_q <= ts_cnt_q;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (wa_en) mem[wa_addr] <= wa_data;
    if (hdr_we) begin
      mem[wr_com_q[AW-1:0]] <= bit_cnt_q;
`ifdef EPC_TIMESTAMP_EN
      mem[hdr_a1] <= ts_q[15:8];
      mem[hdr_a2] <= ts_q[7:0];
`endif
    end
  end

  assign frame_good = good_q;
  assign frame_bad  = bad_q;
  assign overflow   = ovfp_q;

endmodule

// File: tb/tb_epc_reply_buffer.sv
// Directed bench for epc_reply_buffer: a default-size instance and a DEPTH=16 instance for overflow.
module tb_epc_reply_buffer;

  logic clk = 1'b0;
  logic rst, fs, din, vld, crc, rdy, sel16;
  logic [7:0] dat_a, dat_b;
  logic vld_a, vld_b, last_a, last_b, good_a, good_b, bad_a, bad_b, ovf_a, ovf_b;
  logic [7:0] cur_dat;
  logic cur_vld, cur_last, cur_good, cur_bad, cur_ovf;
  int ncomp = 0;
  int nfail = 0;
  logic [7:0] expq [$];
  logic g, b, o;

  always #5 clk = ~clk;

  epc_reply_buffer dut (
    .clk(clk), .rst(rst), .frame_start(fs & ~sel16), .in_dat(din), .in_vld(vld & ~sel16),
    .crc_ok(crc), .out_dat(dat_a), .out_vld(vld_a), .out_rdy(rdy & ~sel16), .out_last(last_a),
    .frame_good(good_a), .frame_bad(bad_a), .overflow(ovf_a)
  );

  epc_reply_buffer #(.DEPTH(16)) dut16 (
    .clk(clk), .rst(rst), .frame_start(fs & sel16), .in_dat(din), .in_vld(vld & sel16),
    .crc_ok(crc), .out_dat(dat_b), .out_vld(vld_b), .out_rdy(rdy & sel16), .out_last(last_b),
    .frame_good(good_b), .frame_bad(bad_b), .overflow(ovf_b)
  );

  assign cur_dat  = sel16 ? dat_b  : dat_a;
  assign cur_vld  = sel16 ? vld_b  : vld_a;
  assign cur_last = sel16 ? last_b : last_a;
  assign cur_good = sel16 ? good_b : good_a;
  assign cur_bad  = sel16 ? bad_b  : bad_a;
  assign cur_ovf  = sel16 ? ovf_b  : ovf_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    fs = 1'b1;
    tick();
    fs = 1'b0;
  endtask

  task automatic send_bit(input logic bv);
    vld = 1'b1;
    din = bv;
    tick();
    vld = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] bv);
    for (int i = 7; i >= 0; i--) send_bit(bv[i]);
  endtask

  task automatic wait_end(input int bound, output logic wg, output logic wb, output logic wo);
    wg = 1'b0;
    wb = 1'b0;
    wo = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (cur_good || cur_bad) begin
        wg = cur_good;
        wb = cur_bad;
        wo = cur_ovf;
        break;
      end
    end
  endtask

  task automatic read_all(input string tag);
    int n;
    n = expq.size();
    rdy = 1'b1;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s vld[%0d]", tag, i), 32'(cur_vld), 32'(1));
      check($sformatf("%s dat[%0d]", tag, i), 32'(cur_dat), 32'(expq[i]));
      check($sformatf("%s last[%0d]", tag, i), 32'(cur_last), 32'(i == n - 1));
      $display("%s: byte %0d = %02h last=%0d", tag, i, cur_dat, cur_last);
      tick();
    end
    rdy = 1'b0;
    check($sformatf("%s drained", tag), 32'(cur_vld), 32'(0));
    expq.delete();
  endtask

  initial begin
    rst = 1'b1; fs = 1'b0; din = 1'b0; vld = 1'b0; crc = 1'b0; rdy = 1'b0; sel16 = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst out_vld", 32'(vld_a), 32'(0));
    check("rst out_dat", 32'(dat_a), 32'(0));
    check("rst out_last", 32'(last_a), 32'(0));
    check("rst frame_good", 32'(good_a), 32'(0));
    check("rst frame_bad", 32'(bad_a), 32'(0));
    check("rst overflow", 32'(ovf_a), 32'(0));
    check("rst out_vld16", 32'(vld_b), 32'(0));

    // 16 bits, good CRC, end by idle timeout
    start_frame(); send_byte(8'hA5); send_byte(8'h3C); crc = 1'b1;
    wait_end(200, g, b, o);
    check("t1 good", 32'(g), 32'(1));
    check("t1 bad", 32'(b), 32'(0));
    check("t1 vld latency", 32'(cur_vld), 32'(1));
    $display("t1: good=%0d bad=%0d ovf=%0d", g, b, o);
    tick();
    check("t1 pulse width", 32'(cur_good), 32'(0));
    expq = '{8'h10, 8'hA5, 8'h3C};
    read_all("t1");

    // 11 bits with zero-padded tail
    start_frame();
    send_byte(8'hB3); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    wait_end(200, g, b, o);
    check("t2 good", 32'(g), 32'(1));
    $display("t2: good=%0d bad=%0d ovf=%0d", g, b, o);
    expq = '{8'h0B, 8'hB3, 8'hA0};
    read_all("t2");

    // CRC fail discards the frame
    crc = 1'b0;
    start_frame(); send_byte(8'hA5); send_byte(8'h3C);
    wait_end(200, g, b, o);
    check("t3 bad", 32'(b), 32'(1));
    check("t3 good", 32'(g), 32'(0));
    check("t3 ovf", 32'(o), 32'(0));
    check("t3 vld", 32'(cur_vld), 32'(0));
    $display("t3: good=%0d bad=%0d ovf=%0d", g, b, o);
    repeat (3) tick();
    check("t3 vld later", 32'(cur_vld), 32'(0));

    // abort mid-frame; the bit coinciding with frame_start is ignored
    crc = 1'b1;
    start_frame();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    fs = 1'b1; vld = 1'b1; din = 1'b0;
    tick();
    fs = 1'b0; vld = 1'b0;
    check("t5 abort bad", 32'(cur_bad), 32'(1));
    check("t5 abort good", 32'(cur_good), 32'(0));
    send_byte(8'hFF);
    wait_end(200, g, b, o);
    check("t5 good", 32'(g), 32'(1));
    $display("t5: good=%0d bad=%0d ovf=%0d", g, b, o);
    expq = '{8'h08, 8'hFF};
    read_all("t5");

    // MAX_BITS ends the frame without waiting for the timeout
    start_frame();
    expq.push_back(8'h80);
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i * 17 + 3));
      expq.push_back(8'(i * 17 + 3));
    end
    wait_end(6, g, b, o);
    check("tmax good", 32'(g), 32'(1));
    $display("tmax: good=%0d bad=%0d ovf=%0d", g, b, o);
    read_all("tmax");

    // reset with committed unread data and a frame in progress
    start_frame(); send_byte(8'h5A);
    wait_end(200, g, b, o);
    check("t6 first good", 32'(g), 32'(1));
    check("t6 unread vld", 32'(cur_vld), 32'(1));
    start_frame(); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6 rst vld", 32'(cur_vld), 32'(0));
    check("t6 rst good", 32'(cur_good), 32'(0));
    check("t6 rst bad", 32'(cur_bad), 32'(0));
    check("t6 rst ovf", 32'(cur_ovf), 32'(0));
    start_frame(); send_byte(8'h81);
    wait_end(200, g, b, o);
    check("t6 good", 32'(g), 32'(1));
    $display("t6: good=%0d bad=%0d ovf=%0d", g, b, o);
    expq = '{8'h08, 8'h81};
    read_all("t6");

    // DEPTH=16, no reads: second 64-bit frame overflows
    sel16 = 1'b1;
    start_frame();
    for (int i = 0; i < 8; i++) send_byte(8'(8'hC0 + i));
    wait_end(200, g, b, o);
    check("t4 first good", 32'(g), 32'(1));
    $display("t4a: good=%0d bad=%0d ovf=%0d", g, b, o);
    start_frame();
    for (int i = 0; i < 8; i++) send_byte(8'(8'hD0 + i));
    wait_end(200, g, b, o);
    check("t4 second bad", 32'(b), 32'(1));
    check("t4 second ovf", 32'(o), 32'(1));
    check("t4 second good", 32'(g), 32'(0));
    check("t4 vld", 32'(cur_vld), 32'(1));
    $display("t4b: good=%0d bad=%0d ovf=%0d", g, b, o);
    expq.push_back(8'h40);
    for (int i = 0; i < 8; i++) expq.push_back(8'(8'hC0 + i));
    read_all("t4");
    sel16 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule

// File: doc/epc_reply_buffer.md
Name: epc_reply_buffer

Overview:
- Downstream consumer of the RX decode path: takes the serial bit stream from bits_detector, frames it between preamble_detected pulses, packs bits MSB-first into bytes, and stores each reply in a byte FIFO.
- A reply becomes visible to readers only if crc16_chk is good at end of frame. Bad or overflowed frames are rolled back.
- Presents committed frames as a valid/ready byte stream (length header + data) for a host/UART stage.

Parameters:
DEPTH, 64, buffer size in bytes; power of 2, min 16
MAX_BITS, 128, max bits per frame; reaching it ends the frame; must be <=255
IDLE_TIMEOUT, 64, clk cycles without in_vld that end a frame

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
frame_start  in  1  one-cycle pulse, driven from preamble_detected
in_dat  in  1  decoded bit (bits_detector out_dat)
in_vld  in  1  in_dat valid strobe
crc_ok  in  1  crc16 chk, sampled at end of frame
out_dat  out  8  byte at read pointer
out_vld  out  1  committed byte available
out_rdy  in  1  consumer accepts byte
out_last  out  1  out_dat is final data byte of a frame
frame_good  out  1  pulse: frame committed
frame_bad  out  1  pulse: frame discarded (CRC fail, abort, or overflow)
overflow  out  1  pulse: frame discarded due to buffer full

Behaviour:
- Reset: all outputs 0, pointers 0, buffer empty, FSM IDLE. Applies mid-frame; an uncommitted frame is lost.
- Pointers are log2(DEPTH)+1 bits: rd, wr_com (committed), wr_spec (speculative). used = wr_spec - rd. A byte write is allowed only if used < DEPTH. Otherwise set ovf_flag and drop the byte.
- Frame layout: [len = bit count][ceil(len/8) data bytes]. The first bit goes to byte0 bit7. A partial last byte is zero-padded in its LSBs.
- FSM states: IDLE, COLLECT, CHECK.
- IDLE, on frame_start:
  - wr_spec <= wr_com+1 (header slot reserved, counted in used).
  - bit_cnt=0, shreg=0, tmo=0, ovf_flag=0. If the header slot does not fit, set ovf_flag=1.
  - Go to COLLECT.
- COLLECT:
  - in_vld shifts in_dat into shreg, bit_cnt++, tmo=0.
  - On every 8th bit, write the byte to mem[wr_spec] and increment wr_spec.
  - With no in_vld, tmo++.
  - tmo==IDLE_TIMEOUT with bit_cnt==0: go to IDLE silently, no pulse, wr_spec <= wr_com.
  - tmo==IDLE_TIMEOUT with bit_cnt>0, or bit_cnt==MAX_BITS: go to CHECK.
- CHECK (one cycle):
  - If bit_cnt%8 != 0, write the padded shreg byte.
  - If crc_ok && !ovf_flag: write mem[wr_com] <= bit_cnt, wr_com <= final wr_spec, pulse frame_good.
  - Otherwise: wr_spec <= wr_com, pulse frame_bad. Also pulse overflow if ovf_flag.
  - Go to IDLE.
- frame_start while in COLLECT: abort the current frame (frame_bad pulse, rollback) and restart in the same cycle as the IDLE entry action.
- frame_start and in_vld in the same cycle: the bit is ignored.
- frame_start during CHECK: acted on next cycle from IDLE.
- Read side:
  - out_vld = (rd != wr_com). out_dat = mem[rd], combinational read. A transfer occurs when out_vld && out_rdy; then rd++.
  - The read-side tracker knows whether rd points at a header. On a header transfer it loads rem = ceil(out_dat/8). Each data transfer decrements rem.
  - out_last = out_vld && data byte && rem==1.
  - Reads never expose wr_spec bytes. Reads and writes may occur in the same cycle. Pointer wrap is natural modulo.
- Pulses are registered and last exactly one cycle. Commit-to-out_vld latency is 1 cycle.

Optional Feature:
- Macro: EPC_TIMESTAMP_EN.
- When defined:
  - A 16-bit free-running cycle counter (wraps, reset to 0) is latched at frame_start.
  - The header becomes 3 bytes: len, ts[15:8], ts[7:0]. Three slots are reserved, and wr_spec <= wr_com+3.
  - The read tracker treats the 3 bytes as header.
- When undefined: 1-byte header, no counter logic.

Test Plan:
- frame_start, 16 bits 0xA5,0x3C, crc_ok=1, idle 64 cycles -> frame_good; stream 0x10,0xA5,0x3C; out_last on 0x3C.
- frame_start, 11 bits 10110011101, crc_ok=1 -> stream 0x0B,0xB3,0xA0; out_last on 0xA0.
- Same as first test with crc_ok=0 -> frame_bad pulse, out_vld stays 0, wr_spec back to wr_com.
- DEPTH=16, out_rdy=0, two 64-bit good frames -> first committed (9 bytes); second gives frame_bad+overflow, buffer holds 9 bytes.
- frame_start, 5 bits, frame_start again, then 8 bits 0xFF, good -> one frame_bad then frame_good; stream 0x08,0xFF only.
- rst asserted mid-COLLECT and with committed unread data -> out_vld=0, all pulses 0 next cycle; a new 8-bit good frame reads back correctly.
